branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
EX-stage producer of branch resolution for the fetch stage and its predictor. Evaluates conditional branches, JAL and JALR against the prediction carried from IF. On a misprediction it issues a same-cycle redirect plus flushes, then squashes wrong-path EX slots for a fixed window. Predictor updates are registered one cycle to keep the EX compare off the predictor write path.

Parameters:
SQUASH_CYCLES, 1, number of cycles after a redirect during which EX inputs are ignored (1..7)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
InstrValidE  in  1  EX holds a real instruction (not a bubble)
StallE  in  1  EX held this cycle; nothing resolves, no state advances except counters hold
BranchE  in  1  conditional branch in EX
JumpE  in  1  JAL in EX
JalrE  in  1  JALR in EX
Funct3E  in  3  branch condition: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
SrcAE  in  32  forwarded rs1
SrcBE  in  32  forwarded rs2
PCE  in  32  PC of EX instruction
ImmExtE  in  32  sign-extended immediate
PredTakenE  in  1  IF predicted taken (with BTB hit) for this instruction
PredTargetE  in  32  IF predicted target
RedirectE  out  1  combinational: fetch must load RedirectPCE next edge
RedirectPCE  out  32  correct next PC
FlushD  out  1  flush IF/ID (equals RedirectE)
FlushE  out  1  flush ID/EX (equals RedirectE)
UpdateEnM  out  1  registered predictor update strobe
UpdatePCM  out  32  registered PC of resolved branch
UpdateTakenM  out  1  registered actual direction
UpdateTargetM  out  32  registered actual target
BranchCount  out  CNT_W  resolved control-flow instructions
MispredCount  out  CNT_W  redirects issued

Behaviour:
- Active = InstrValidE & ~StallE & (state == IDLE). Ctrl = BranchE | JumpE | JalrE.
- Target: JalrE ? ((SrcAE + ImmExtE) & ~32'h1) : (PCE + ImmExtE); 32-bit wraparound, no overflow detect.
- Taken: JumpE|JalrE -> 1; BranchE -> condition from Funct3E (signed compare for 100/101, unsigned for 110/111); undefined Funct3E (010/011) -> not taken. Non-control -> 0.
- Mispredict (when Active): Taken != PredTakenE, or Taken & PredTakenE & (Target != PredTargetE). Non-control with PredTakenE=1 (BTB alias) is a mispredict.
- RedirectE = Active & Mispredict. RedirectPCE = Taken ? Target : PCE + 4 (0 when RedirectE=0). FlushD = FlushE = RedirectE. Zero latency, combinational.
- Update register: on each edge, UpdateEnM <= Active & Ctrl; UpdatePCM/UpdateTakenM/UpdateTargetM <= PCE/Taken/Target when Active & Ctrl, else hold. One-cycle pulse per resolved control instruction; non-control aliases do not update.
- FSM: IDLE -> SQUASH on RedirectE, loading down-counter with SQUASH_CYCLES-1. SQUASH: Active forced 0; if StallE hold, else if counter==0 -> IDLE, else decrement. SQUASH_CYCLES=1 means exactly one ignored cycle.
- StallE=1 in IDLE: no redirect, no update, repeated evaluation next unstalled cycle (no double count).
- Reset (async, mid-squash included): state=IDLE, counter=0, UpdateEnM=0, UpdatePCM/UpdateTargetM=0, UpdateTakenM=0, counters=0. Combinational outputs 0 while reset asserted.

Optional Feature:
BRU_PERF_CNT_EN: when defined, BranchCount increments on every Active & Ctrl cycle and MispredCount on every RedirectE, both saturating at all-ones. When undefined, both outputs tied to 0 and no counter flops exist.

Test Plan:
- beq, SrcAE=SrcBE=5, PCE=0x100, Imm=0x20, PredTakenE=0 -> RedirectE=1, RedirectPCE=0x120, FlushD/E=1; next cycle UpdateEnM=1, UpdateTakenM=1, UpdateTargetM=0x120.
- blt SrcAE=0xFFFFFFFF, SrcBE=1 taken; bltu same operands not taken; PredTakenE=0 both -> first redirects to target, second no redirect, UpdateEnM pulses for both.
- JALR SrcAE=0x203, Imm=0x4, PredTakenE=1, PredTargetE=0x206 -> target 0x206, no redirect; PredTargetE=0x208 -> redirect to 0x206.
- Non-control at PCE=0x40 with PredTakenE=1 -> RedirectE=1, RedirectPCE=0x44, UpdateEnM stays 0.
- SQUASH_CYCLES=2: mispredict then valid mispredicting branches on next 2 cycles -> both ignored; third cycle resolves; StallE during SQUASH extends window.
- Assert reset low while in SQUASH with UpdateEnM=1 -> all outputs 0 immediately; after release, first branch resolves normally; with BRU_PERF_CNT_EN, counters restart at 0 and saturate at 2^CNT_W-1 (CNT_W=4 run).

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// EX-stage <-> branch resolve unit bundle: resolve inputs from EX, redirect/flush
// to fetch, registered predictor update. master = EX/pipeline side, slave = BRU.
interface branch_resolve_unit_if;
  logic        InstrValidE;
  logic        StallE;
  logic        BranchE;
  logic        JumpE;
  logic        JalrE;
  logic [2:0]  Funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [31:0] PCE;
  logic [31:0] ImmExtE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        RedirectE;
  logic [31:0] RedirectPCE;
  logic        FlushD;
  logic        FlushE;
  logic        UpdateEnM;
  logic [31:0] UpdatePCM;
  logic        UpdateTakenM;
  logic [31:0] UpdateTargetM;

  modport master (
    output InstrValidE, StallE, BranchE, JumpE, JalrE, Funct3E,
           SrcAE, SrcBE, PCE, ImmExtE, PredTakenE, PredTargetE,
    input  RedirectE, RedirectPCE, FlushD, FlushE,
           UpdateEnM, UpdatePCM, UpdateTakenM, UpdateTargetM
  );

  modport slave (
    input  InstrValidE, StallE, BranchE, JumpE, JalrE, Funct3E,
           SrcAE, SrcBE, PCE, ImmExtE, PredTakenE, PredTargetE,
    output RedirectE, RedirectPCE, FlushD, FlushE,
           UpdateEnM, UpdatePCM, UpdateTakenM, UpdateTargetM
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/JAL/JALR resolution: same-cycle redirect + flush, wrong-path squash
// window, registered predictor update. Optional perf counters: define BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_resolve_unit_if.slave    bus,
  output logic [CNT_W-1:0]        BranchCount,
  output logic [CNT_W-1:0]        MispredCount
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic [0:0]  state;
  logic [2:0]  sq_cnt;

  logic        active;
  logic        ctrl;
  logic        cond;
  logic        taken;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic        mispredict;
  logic        redirect;

  // Reset level gates the combinational outputs so nothing escapes while held in reset.
  assign active = reset & bus.InstrValidE & ~bus.StallE & (state == IDLE);
  assign ctrl   = bus.BranchE | bus.JumpE | bus.JalrE;
  assign seq_pc = bus.PCE + 32'd4;

  always_comb begin
    cond = 1'b0;
    case (bus.Funct3E)
      3'b000:  cond = (bus.SrcAE == bus.SrcBE);
      3'b001:  cond = (bus.SrcAE != bus.SrcBE);
      3'b100:  cond = ($signed(bus.SrcAE) <  $signed(bus.SrcBE));
      3'b101:  cond = ($signed(bus.SrcAE) >= $signed(bus.SrcBE));
      3'b110:  cond = (bus.SrcAE <  bus.SrcBE);
      3'b111:  cond = (bus.SrcAE >= bus.SrcBE);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    target = '0;
    if (bus.JalrE)
      target = (bus.SrcAE + bus.ImmExtE) & ~32'h1;
    else
      target = bus.PCE + bus.ImmExtE;
  end

  always_comb begin
    taken = 1'b0;
    if (bus.JumpE | bus.JalrE)
      taken = 1'b1;
    else if (bus.BranchE)
      taken = cond;
  end

  // A taken prediction on a non-control instruction (BTB alias) falls out as a direction mismatch.
  assign mispredict = (taken != bus.PredTakenE) |
                      (taken & bus.PredTakenE & (target != bus.PredTargetE));
  assign redirect   = active & mispredict;

  always_comb begin
    bus.RedirectE   = redirect;
    bus.FlushD      = redirect;
    bus.FlushE      = redirect;
    bus.RedirectPCE = '0;
    if (redirect)
      bus.RedirectPCE = taken ? target : seq_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.UpdateEnM     <= 1'b0;
      bus.UpdatePCM     <= '0;
      bus.UpdateTakenM  <= 1'b0;
      bus.UpdateTargetM <= '0;
    end else begin
      bus.UpdateEnM <= active & ctrl;
      if (active & ctrl) begin
        bus.UpdatePCM     <= bus.PCE;
        bus.UpdateTakenM  <= taken;
        bus.UpdateTargetM <= target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sq_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            state  <= SQUASH;
            sq_cnt <= 3'(SQUASH_CYCLES - 1);
          end
        end
        SQUASH: begin
          if (!bus.StallE) begin
            if (sq_cnt == '0)
              state <= IDLE;
            else
              sq_cnt <= sq_cnt - 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          sq_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if ((active & ctrl) && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (redirect && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

  assign BranchCount  = branch_cnt;
  assign MispredCount = mispred_cnt;
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected redirects and
// updates (tagged with the cycle they must appear in); a negedge monitor pops and compares.
module tb_branch_resolve_unit;

  localparam int unsigned CNT_W = 4;
`ifdef BRU_PERF_CNT_EN
  localparam logic [31:0] PRE_BR  = 32'd11;
  localparam logic [31:0] PRE_MIS = 32'd7;
  localparam logic [31:0] SAT     = 32'd15;
`else
  localparam logic [31:0] PRE_BR  = 32'd0;
  localparam logic [31:0] PRE_MIS = 32'd0;
  localparam logic [31:0] SAT     = 32'd0;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] bc;
  logic [CNT_W-1:0] mc;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 0;
  exp_t redir_q[$];
  exp_t upd_q[$];

  branch_resolve_unit_if bif ();

  branch_resolve_unit #(.SQUASH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bif),
    .BranchCount  (bc),
    .MispredCount (mc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_in(input logic v, input logic st, input logic br, input logic j,
                        input logic jr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg);
    bif.InstrValidE = v;   bif.StallE  = st;  bif.BranchE = br;
    bif.JumpE       = j;   bif.JalrE   = jr;  bif.Funct3E = f3;
    bif.SrcAE       = a;   bif.SrcBE   = b;   bif.PCE     = pc;
    bif.ImmExtE     = imm; bif.PredTakenE = pt; bif.PredTargetE = ptg;
  endtask

  // One EX cycle; er/erpc = expected redirect, eu/eut/eutg = expected update next cycle.
  task automatic step(input logic v, input logic st, input logic br, input logic j,
                      input logic jr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                      input logic pt, input logic [31:0] ptg,
                      input logic er, input logic [31:0] erpc,
                      input logic eu, input logic eut, input logic [31:0] eutg);
    exp_t e;
    @(posedge clk); #1;
    set_in(v, st, br, j, jr, f3, a, b, pc, imm, pt, ptg);
    if (er) begin
      e.cyc = cyc; e.pc = erpc; e.taken = 1'b0; e.tgt = '0;
      redir_q.push_back(e);
    end
    if (eu) begin
      e.cyc = cyc + 1; e.pc = pc; e.taken = eut; e.tgt = eutg;
      upd_q.push_back(e);
    end
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // A branch that would redirect if it were not squashed.
  task automatic wrong_path(input logic st);
    step(1, st, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!done && reset === 1'b1) begin
      if (bif.RedirectE) begin
        chk("redirect_expected", 32'(redir_q.size() != 0), 32'd1);
        if (redir_q.size() != 0) begin
          e = redir_q.pop_front();
          chk("redirect_cycle", cyc, e.cyc);
          chk("redirect_pc", bif.RedirectPCE, e.pc);
          chk("flush_d", 32'(bif.FlushD), 32'd1);
          chk("flush_e", 32'(bif.FlushE), 32'd1);
        end
      end else begin
        chk("redirect_pc_idle", bif.RedirectPCE, 32'd0);
        chk("flush_idle", 32'({bif.FlushD, bif.FlushE}), 32'd0);
      end
      if (bif.UpdateEnM) begin
        chk("update_expected", 32'(upd_q.size() != 0), 32'd1);
        if (upd_q.size() != 0) begin
          e = upd_q.pop_front();
          chk("update_cycle", cyc, e.cyc);
          chk("update_pc", bif.UpdatePCM, e.pc);
          chk("update_taken", 32'(bif.UpdateTakenM), 32'(e.taken));
          chk("update_target", bif.UpdateTargetM, e.tgt);
        end
      end
    end
  end

  initial begin
    // Reset held with a mispredicting alias on the inputs: nothing may escape.
    reset = 1'b0;
    set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h40, 0, 1, 32'h80);
    #2;
    chk("rst_redirect", 32'(bif.RedirectE), 32'd0);
    chk("rst_redirect_pc", bif.RedirectPCE, 32'd0);
    chk("rst_update_en", 32'(bif.UpdateEnM), 32'd0);
    chk("rst_update_pc", bif.UpdatePCM, 32'd0);
    chk("rst_counts", 32'({bc, mc}), 32'd0);
    set_in(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;

    //   v st br j jr f3      A             B             PC        Imm           pt PredTgt      er RedirPC      eu et UpdTgt
    step(1, 0, 1, 0, 0, 3'b000, 32'd5,        32'd5,        32'h100, 32'h20,       0, 0,           1, 32'h120,     1, 1, 32'h120);
    wrong_path(0);
    wrong_path(0);
    step(1, 0, 1, 0, 0, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h200, 32'h40,       0, 0,           1, 32'h240,     1, 1, 32'h240);
    bubble(2);
    step(1, 0, 1, 0, 0, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h300, 32'h40,       0, 0,           0, 0,           1, 0, 32'h340);
    step(1, 0, 0, 0, 1, 3'b000, 32'h203,      32'd0,        32'h400, 32'h4,        1, 32'h206,     0, 0,           1, 1, 32'h206);
    step(1, 0, 0, 0, 1, 3'b000, 32'h203,      32'd0,        32'h404, 32'h4,        1, 32'h208,     1, 32'h206,     1, 1, 32'h206);
    wrong_path(1);
    wrong_path(0);
    wrong_path(0);
    step(1, 0, 0, 0, 0, 3'b000, 32'd0,        32'd0,        32'h40,  32'h0,        1, 32'h80,      1, 32'h44,      0, 0, 0);
    bubble(2);
    step(1, 0, 1, 0, 0, 3'b101, 32'd3,        32'd3,        32'h500, 32'hFFFFFFF0, 1, 32'h4F0,     0, 0,           1, 1, 32'h4F0);
    step(1, 1, 1, 0, 0, 3'b001, 32'd1,        32'd2,        32'h600, 32'h8,        0, 0,           0, 0,           0, 0, 0);
    step(1, 0, 1, 0, 0, 3'b001, 32'd1,        32'd2,        32'h600, 32'h8,        0, 0,           1, 32'h608,     1, 1, 32'h608);
    bubble(2);
    step(1, 0, 1, 0, 0, 3'b010, 32'd1,        32'd1,        32'h700, 32'h10,       0, 0,           0, 0,           1, 0, 32'h710);
    step(1, 0, 0, 1, 0, 3'b000, 32'd0,        32'd0,        32'h800, 32'h100,      1, 32'h900,     0, 0,           1, 1, 32'h900);
    step(1, 0, 1, 0, 0, 3'b111, 32'd1,        32'hFFFFFFFF, 32'h900, 32'h10,       1, 32'h910,     1, 32'h904,     1, 0, 32'h910);
    bubble(2);
    // Mispredict, then reset lands mid-squash while its update strobe is high.
    step(1, 0, 1, 0, 0, 3'b000, 32'd1,        32'd2,        32'hA00, 32'h10,       1, 32'hA10,     1, 32'hA04,     0, 0, 0);
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_update_en", 32'(bif.UpdateEnM), 32'd1);
    chk("pre_rst_update_pc", bif.UpdatePCM, 32'hA00);
    chk("pre_rst_branch_cnt", 32'(bc), PRE_BR);
    chk("pre_rst_mispred_cnt", 32'(mc), PRE_MIS);
    reset = 1'b0;
    #1;
    chk("mid_rst_update_en", 32'(bif.UpdateEnM), 32'd0);
    chk("mid_rst_update_pc", bif.UpdatePCM, 32'd0);
    chk("mid_rst_update_tgt", bif.UpdateTargetM, 32'd0);
    chk("mid_rst_update_taken", 32'(bif.UpdateTakenM), 32'd0);
    chk("mid_rst_redirect", 32'(bif.RedirectE), 32'd0);
    chk("mid_rst_counts", 32'({bc, mc}), 32'd0);
    @(negedge clk); reset = 1'b1;

    step(1, 0, 1, 0, 0, 3'b000, 32'd7,        32'd7,        32'hB00, 32'h8,        1, 32'hB08,     0, 0,           1, 1, 32'hB08);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'hC00 + 32'(i) * 32'h10, 32'h20, 0, 0,
           1, 32'hC20 + 32'(i) * 32'h10, 1, 1, 32'hC20 + 32'(i) * 32'h10);
      bubble(2);
    end
    bubble(2);
    chk("sat_branch_cnt", 32'(bc), SAT);
    chk("sat_mispred_cnt", 32'(mc), SAT);
    chk("redirect_queue_drained", 32'(redir_q.size()), 32'd0);
    chk("update_queue_drained", 32'(upd_q.size()), 32'd0);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
